// File: rtl/video_packet_mux_send.sv
// video_packet_mux_send: round-robin K-code packet framer merging per-channel video lines onto one gt lane
module video_packet_mux_send #(
  parameter int CH_NUM  = 4,
  parameter int CH_W    = 3,
  parameter bit CSUM_EN = 1'b1
) (
  input  logic                 tx_clk,
  input  logic                 rst_n,
  input  logic [CH_NUM-1:0]    ch_vs_pulse,
  input  logic [CH_NUM-1:0]    ch_line_ready,
  output logic [CH_NUM-1:0]    ch_rd_en,
  input  logic [CH_NUM*32-1:0] ch_rd_data,
  input  logic [15:0]          line_words,
  output logic [31:0]          gt_tx_data,
  output logic [3:0]           gt_tx_ctrl,
  output logic                 busy,
  output logic [CH_W-1:0]      cur_ch
);

  typedef enum logic [3:0] {
    S_RST, S_IDLE0, S_IDLE1, S_SYNC0, S_SYNC1, S_LSTART, S_LNUM, S_DATA, S_LEND, S_CSUM
  } state_t;

  state_t            st, ns;
  logic [CH_NUM-1:0] sync_pend;
  logic [15:0]       line_num [CH_NUM];
  logic [CH_W-1:0]   rr, gnt, sync_g, line_g;
  logic              sync_hit, line_hit;
  logic [15:0]       lw_q, wcnt, rd_left;
  logic [31:0]       csum, rd_word, nx_data;
  logic [3:0]        nx_ctrl;
  logic [7:0]        ch8;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int i);
    return CH_W'((int'(base) + i) % CH_NUM);
  endfunction

  assign ch8     = 8'(gnt);
  assign rd_word = ch_rd_data[32*int'(cur_ch) +: 32];

  // round-robin search from the channel after the last grant; the nearest requester wins
  always_comb begin
    sync_hit = 1'b0;
    line_hit = 1'b0;
    sync_g   = '0;
    line_g   = '0;
    for (int i = CH_NUM; i >= 1; i--) begin
      if (sync_pend[rr_idx(rr, i)]) begin
        sync_hit = 1'b1;
        sync_g   = rr_idx(rr, i);
      end
      if (ch_line_ready[rr_idx(rr, i)] && line_words != 16'd0) begin
        line_hit = 1'b1;
        line_g   = rr_idx(rr, i);
      end
    end
  end

  // state register
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) st <= S_RST;
    else        st <= ns;
  end

  // next state and grant; syncs take priority over lines at the decision point
  always_comb begin
    ns  = st;
    gnt = cur_ch;
    case (st)
      S_RST:    ns = S_IDLE0;
      S_IDLE0:  ns = S_IDLE1;
      S_IDLE1: begin
        ns  = sync_hit ? S_SYNC0 : line_hit ? S_LSTART : S_IDLE0;
        gnt = sync_hit ? sync_g : line_hit ? line_g : cur_ch;
      end
      S_SYNC0:  ns = S_SYNC1;
      S_SYNC1:  ns = S_IDLE0;
      S_LSTART: ns = S_LNUM;
      S_LNUM:   ns = S_DATA;
      S_DATA:   ns = (wcnt == lw_q) ? S_LEND : S_DATA;
      S_LEND:   ns = CSUM_EN ? S_CSUM : S_IDLE0;
      S_CSUM:   ns = S_IDLE0;
      default:  ns = S_IDLE0;
    endcase
  end

  // lane word for the state being entered; registered below
  always_comb begin
    nx_data = 32'h0;
    nx_ctrl = 4'b0001;
    case (ns)
      S_IDLE0:  nx_data = 32'hff55_55bc;
      S_IDLE1:  nx_data = 32'hffaa_aabc;
      S_SYNC0:  nx_data = {8'hff, ch8, 8'h00, 8'hbc};
      S_SYNC1:  nx_data = {8'hff, ch8, 8'h01, 8'hbc};
      S_LSTART: nx_data = {8'hff, ch8, 8'h02, 8'hbc};
      S_LEND:   nx_data = {8'hff, ch8, 8'h03, 8'hbc};
      S_LNUM: begin
        nx_data = {16'h0000, line_num[gnt]};
        nx_ctrl = 4'b0000;
      end
      S_DATA: begin
        nx_data = rd_word;
        nx_ctrl = 4'b0000;
      end
      S_CSUM: begin
        nx_data = csum;
        nx_ctrl = 4'b0000;
      end
      default:  nx_ctrl = 4'b0000;
    endcase
  end

  // registered lane outputs, grant bookkeeping, read strobe and checksum
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_tx_data <= '0;
      gt_tx_ctrl <= '0;
      busy       <= 1'b0;
      cur_ch     <= '0;
      rr         <= CH_W'(CH_NUM - 1);
      lw_q       <= '0;
      wcnt       <= '0;
      rd_left    <= '0;
      ch_rd_en   <= '0;
      csum       <= '0;
    end else begin
      gt_tx_data <= nx_data;
      gt_tx_ctrl <= nx_ctrl;
      busy       <= (ns != S_IDLE0) && (ns != S_IDLE1);
      cur_ch     <= gnt;
      rr         <= (st == S_IDLE1 && (sync_hit || line_hit)) ? gnt : rr;
      wcnt       <= (ns == S_DATA) ? ((st == S_DATA) ? wcnt + 16'd1 : 16'd1) : 16'd0;
      csum       <= (ns == S_LSTART) ? 32'h0 : (ns == S_DATA) ? csum ^ rd_word : csum;
      if (ns == S_LSTART) begin
        lw_q     <= line_words;
        rd_left  <= line_words - 16'd1;
        ch_rd_en <= CH_NUM'(1) << gnt;
      end else if (rd_left != 16'd0) begin
        rd_left  <= rd_left - 16'd1;
      end else begin
        ch_rd_en <= '0;
      end
    end
  end

  // sticky sync requests and per-channel line counters; a pulse during SYNC1 re-arms the flag
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pend <= '0;
      for (int i = 0; i < CH_NUM; i++) line_num[i] <= '0;
    end else begin
      sync_pend <= (sync_pend & ~((st == S_SYNC1) ? CH_NUM'(1) << cur_ch : '0)) | ch_vs_pulse;
      for (int i = 0; i < CH_NUM; i++) begin
        if (st == S_SYNC1 && int'(cur_ch) == i)     line_num[i] <= 16'd0;
        else if (st == S_LEND && int'(cur_ch) == i) line_num[i] <= line_num[i] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_packet_mux_send.sv
// tb_video_packet_mux_send: randomized lane check against a packet-level reference model
module tb_video_packet_mux_send;
  localparam int CH      = 4;
  localparam int CW      = 3;
  localparam bit CSUM_EN = 1'b1;

  logic              tx_clk = 1'b0;
  logic              rst_n  = 1'b0;
  logic [CH-1:0]     ch_vs_pulse = '0;
  logic [CH-1:0]     ch_line_ready = '0;
  logic [CH-1:0]     ch_rd_en;
  logic [CH*32-1:0]  ch_rd_data = '0;
  logic [15:0]       line_words = '0;
  logic [31:0]       gt_tx_data;
  logic [3:0]        gt_tx_ctrl;
  logic              busy;
  logic [CW-1:0]     cur_ch;

  video_packet_mux_send #(.CH_NUM(CH), .CH_W(CW), .CSUM_EN(CSUM_EN)) dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .ch_vs_pulse(ch_vs_pulse), .ch_line_ready(ch_line_ready),
    .ch_rd_en(ch_rd_en), .ch_rd_data(ch_rd_data), .line_words(line_words),
    .gt_tx_data(gt_tx_data), .gt_tx_ctrl(gt_tx_ctrl), .busy(busy), .cur_ch(cur_ch)
  );

  always #5 tx_clk = ~tx_clk;

  // kind: 0 idle, 1 busy literal, 2 line data, 3 checksum, 4 SYNC1
  typedef struct {
    int          kind;
    logic [31:0] w;
    logic [3:0]  c;
  } tok_t;

  tok_t          exq[$];
  logic [31:0]   dq[$];
  int            n_chk = 0, n_fail = 0;
  logic [CH-1:0] pend, prev_rd, force_pulse;
  logic [15:0]   ln [CH];
  int            rr, curg, rd_left;
  logic [31:0]   xacc;
  int            pulse_pct, lw_lo, lw_hi, fi;
  logic [CH-1:0] rdy_on;
  bit            rdy_rand, data_fixed;
  logic [31:0]   fixed_d [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic tok_t tk(input int kind, input logic [31:0] w, input logic [3:0] c);
    tok_t t;
    t.kind = kind;
    t.w    = w;
    t.c    = c;
    return t;
  endfunction

  function automatic int rr_next(input logic [CH-1:0] m);
    for (int i = 1; i <= CH; i++) if (m[(rr + i) % CH]) return (rr + i) % CH;
    return 0;
  endfunction

  function automatic logic [31:0] kword(input int g, input logic [7:0] code);
    return {8'hff, 8'(g), code, 8'hbc};
  endfunction

  task automatic push_idle();
    exq.push_back(tk(0, 32'hff55_55bc, 4'b0001));
    exq.push_back(tk(0, 32'hffaa_aabc, 4'b0001));
  endtask

  task automatic model_reset();
    exq.delete();
    dq.delete();
    pend    = '0;
    prev_rd = '0;
    for (int i = 0; i < CH; i++) ln[i] = '0;
    rr      = CH - 1;
    curg    = 0;
    rd_left = 0;
    xacc    = '0;
    push_idle();
  endtask

  task automatic check_reset_vals();
    chk("rst_data", gt_tx_data, 32'h0);
    chk("rst_ctrl", 32'(gt_tx_ctrl), 32'h0);
    chk("rst_rd_en", 32'(ch_rd_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cur_ch", 32'(cur_ch), 32'h0);
  endtask

  // one lane cycle: check the observed word, answer FIFO reads, drive new inputs, advance the model
  task automatic cycle();
    tok_t          t;
    logic [31:0]   ew, d;
    logic [CH-1:0] erd, req, pl;
    int            g, lw;
    @(negedge tx_clk);
    t  = exq.pop_front();
    ew = t.w;
    if (t.kind == 2) begin
      if (dq.size() != 0) ew = dq.pop_front();
      else ew = ~gt_tx_data;
      xacc ^= ew;
    end
    if (t.kind == 3) ew = xacc;
    chk("lane_data", gt_tx_data, ew);
    chk("lane_ctrl", 32'(gt_tx_ctrl), 32'(t.c));
    chk("busy", 32'(busy), 32'(t.kind != 0));
    chk("cur_ch", 32'(cur_ch), 32'(curg));
    erd = (rd_left > 0) ? CH'(1) << curg : '0;
    chk("rd_en", 32'(ch_rd_en), 32'(erd));
    if (rd_left > 0) rd_left--;
    for (int i = 0; i < CH; i++) begin
      if (prev_rd[i]) begin
        d = data_fixed ? fixed_d[fi % 4] : $urandom;
        fi++;
        dq.push_back(d);
      end else d = $urandom;
      ch_rd_data[32*i +: 32] = d;
    end
    prev_rd     = ch_rd_en;
    pl          = force_pulse;
    force_pulse = '0;
    for (int i = 0; i < CH; i++) if ($urandom_range(99) < pulse_pct) pl[i] = 1'b1;
    ch_vs_pulse   = pl;
    ch_line_ready = rdy_rand ? (CH'($urandom) & rdy_on) : rdy_on;
    line_words    = 16'($urandom_range(lw_hi, lw_lo));
    if (exq.size() == 0) begin
      req = (line_words != 0) ? ch_line_ready : '0;
      if (pend != 0) begin
        g = rr_next(pend);
        rr = g; curg = g; ln[g] = '0;
        exq.push_back(tk(1, kword(g, 8'h00), 4'b0001));
        exq.push_back(tk(4, kword(g, 8'h01), 4'b0001));
      end else if (req != 0) begin
        g = rr_next(req);
        rr = g; curg = g; lw = int'(line_words);
        exq.push_back(tk(1, kword(g, 8'h02), 4'b0001));
        exq.push_back(tk(1, {16'h0, ln[g]}, 4'b0000));
        for (int k = 0; k < lw; k++) exq.push_back(tk(2, 32'h0, 4'b0000));
        exq.push_back(tk(1, kword(g, 8'h03), 4'b0001));
        if (CSUM_EN) exq.push_back(tk(3, 32'h0, 4'b0000));
        ln[g]++;
        rd_left = lw;
        xacc    = '0;
      end
      push_idle();
    end
    if (t.kind == 4) pend[curg] = 1'b0;
    pend |= pl;
  endtask

  task automatic reset_release();
    @(negedge tx_clk);
    ch_vs_pulse = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    fixed_d = '{32'h11, 32'h22, 32'h44, 32'h88};
    pulse_pct = 0; rdy_on = '0; rdy_rand = 1'b0; data_fixed = 1'b0;
    lw_lo = 4; lw_hi = 4; fi = 0; force_pulse = '0;
    model_reset();
    repeat (3) @(negedge tx_clk);
    #1 check_reset_vals();
    reset_release();
    repeat (12) cycle();
    rdy_on = 4'b0100; data_fixed = 1'b1;
    repeat (30) cycle();
    data_fixed = 1'b0;
    rdy_on = '1; lw_lo = 2; lw_hi = 2;
    repeat (60) cycle();
    rdy_on = 4'b0010; lw_lo = 3; lw_hi = 6;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      if (exq.size() > 0 && exq[0].kind == 2 && curg == 1) found = 1'b1;
    end
    chk("wait_ch1_data", 32'(found), 32'h1);
    force_pulse = 4'b0010;
    repeat (40) cycle();
    rdy_on = '1; lw_lo = 0; lw_hi = 0;
    force_pulse = 4'b0001; cycle();
    force_pulse = 4'b0001; cycle();
    repeat (20) cycle();
    force_pulse = 4'b0100; cycle();
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      cycle();
      if (exq.size() > 0 && exq[0].kind == 4) found = 1'b1;
    end
    chk("wait_sync1", 32'(found), 32'h1);
    force_pulse = CH'(1) << curg;
    repeat (20) cycle();
    pulse_pct = 5;
    repeat (100) cycle();
    pulse_pct = 3; rdy_rand = 1'b1; lw_lo = 0; lw_hi = 5;
    repeat (1500) cycle();
    pulse_pct = 0; rdy_rand = 1'b0; rdy_on = '1; lw_lo = 4; lw_hi = 4;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      if (exq.size() > 0 && exq[0].kind == 2) found = 1'b1;
    end
    chk("wait_mid_line", 32'(found), 32'h1);
    #3 rst_n = 1'b0;
    #1 check_reset_vals();
    model_reset();
    reset_release();
    repeat (40) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
